ram_sp_be_clr: RTL and testbench
================================

Name: ram_sp_be_clr

Overview:
Parametrised single-port synchronous RAM for the scaler's line/coefficient storage. It is the successor to the team's basic single-port RAM and adds:
- per-byte write enables
- a registered read port with a data-valid flag
- selectable read-during-write behaviour
- a built-in clear engine that fills memory with a constant after reset or on request

Clients must check o_busy before issuing accesses.

Parameters:
ADDR_WIDTH, 8, address bits.
DATA_WIDTH, 32, word width; must be a multiple of 8.
BE_WIDTH, DATA_WIDTH/8, byte-enable width (derived, not overridden).
RAM_DEPTH, 1<<ADDR_WIDTH, number of words; may be less than 2^ADDR_WIDTH.
RDW_MODE, 0, write-cycle output: 0 = no output, 1 = write-first (new word), 2 = read-first (old word).
CLEAR_ON_RESET, 1, 1 = run the clear engine automatically after reset.
CLEAR_VALUE, 0, DATA_WIDTH-bit fill value used by the clear engine.

Ports:
clk  input  1  clock; all logic on rising edge.
i_rst  input  1  asynchronous, active-high reset.
i_cs  input  1  chip select; an access occurs when high and not busy.
i_we  input  1  1 = write, 0 = read (qualified by i_cs).
i_be  input  BE_WIDTH  byte enables for writes; bit k covers bits [8k+7:8k].
i_addr  input  ADDR_WIDTH  word address.
i_din  input  DATA_WIDTH  write data.
i_clear  input  1  single-cycle request to start a clear pass.
o_dout  output  DATA_WIDTH  registered read data; holds its value between reads.
o_dvalid  output  1  one-cycle pulse marking o_dout updated this cycle.
o_busy  output  1  high while the clear engine owns the array.

Behaviour:
- Reset (asynchronous, active-high): o_dout=0, o_dvalid=0, clear address=0.
  - state = CLEAR and o_busy=1 if CLEAR_ON_RESET=1; otherwise state = IDLE and o_busy=0.
  - Array contents are not reset.
  - Reset asserted mid-clear restarts the clear from address 0 on release.
- FSM has two states, IDLE and CLEAR.
  - IDLE->CLEAR on i_clear=1; o_busy goes high on the next edge.
  - CLEAR: each cycle writes CLEAR_VALUE to the clear address, then increments it.
  - After writing address RAM_DEPTH-1: state->IDLE, o_busy->0, clear address->0.
  - A pass is exactly RAM_DEPTH cycles of o_busy=1.
- i_clear while in CLEAR is ignored; there is no restart and no queueing.
- Any i_cs access while o_busy=1 is dropped: no write, no o_dvalid.
- Simultaneous i_clear and access in IDLE: the access completes normally this cycle and the clear starts next cycle. A write is therefore later overwritten.
- Read (i_cs=1, i_we=0, IDLE): o_dout = mem[i_addr] and o_dvalid=1 at the next edge (1-cycle latency). Back-to-back reads give one word per cycle.
- Write (i_cs=1, i_we=1, IDLE): only bytes with i_be[k]=1 are updated at the edge; i_be=0 leaves the word unchanged. Output on a write cycle depends on RDW_MODE:
  - 0: o_dvalid=0, o_dout holds.
  - 1: o_dout = merged new word, o_dvalid=1.
  - 2: o_dout = pre-write word, o_dvalid=1.
- Out-of-range address (i_addr >= RAM_DEPTH):
  - write is dropped;
  - read (or RDW output) returns 0 with o_dvalid=1.
- No access (i_cs=0): o_dvalid=0 and o_dout holds its last value.
- The clear address counter is sized to reach RAM_DEPTH-1 exactly, with no wrap past the last word.

Test Plan:
- Reset with CLEAR_ON_RESET=1, RAM_DEPTH=256, CLEAR_VALUE=32'hA5A5A5A5 -> o_busy=1 for exactly 256 cycles after release; then reads of addr 0, 128, 255 return 32'hA5A5A5A5 one cycle later with o_dvalid=1.
- Byte-enable merge:
  - write 32'h11223344 with be=4'hF to addr 5;
  - write 32'hAABBCCDD with be=4'b0101;
  - read addr 5 -> 32'h11BB33DD.
  - A write with be=0 leaves the word unchanged.
- Read-during-write: addr 9 holds 32'h0; write 32'hCAFEF00D, be=4'hF ->
  - RDW_MODE=0: o_dvalid=0;
  - RDW_MODE=1: o_dout=32'hCAFEF00D;
  - RDW_MODE=2: o_dout=0.
  - In both modes 1 and 2, o_dvalid=1.
- Clear interactions:
  - pulse i_clear together with a write of 32'h5 to addr 3 -> the write lands, then o_busy rises next cycle;
  - writes issued during busy are dropped;
  - after the pass, addr 3 reads CLEAR_VALUE.
- Reset mid-clear: assert i_rst at clear address 100 -> o_busy stays 1; after release the pass runs a full 256 cycles starting from address 0.
- RAM_DEPTH=200, ADDR_WIDTH=8: write 32'h7 to addr 210 -> dropped; read addr 210 -> o_dout=0 with o_dvalid=1. Addr 199 write/read round-trips correctly.

Source files
------------

// File: rtl/ram_sp_be_clr.sv
// Single-port synchronous RAM with per-byte write enables, a registered read
// port with a data-valid pulse, selectable read-during-write output and a clear engine.
module ram_sp_be_clr #(
  parameter int                    ADDR_WIDTH     = 8,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    RAM_DEPTH      = 1 << ADDR_WIDTH,
  parameter int                    RDW_MODE       = 0,
  parameter int                    CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0,
  localparam int                   BE_WIDTH       = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic                  i_cs,
  input  logic                  i_we,
  input  logic [BE_WIDTH-1:0]   i_be,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_din,
  input  logic                  i_clear,
  output logic [DATA_WIDTH-1:0] o_dout,
  output logic                  o_dvalid,
  output logic                  o_busy
);

  localparam int IDX_W = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [IDX_W-1:0]    LAST_ADDR = IDX_W'(RAM_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_L   = (ADDR_WIDTH + 1)'(RAM_DEPTH);

  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  w_busy;
  logic [IDX_W-1:0]      r_clr_addr;
  logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_dvalid;

  logic [IDX_W-1:0]      w_idx;
  logic                  w_in_range;
  logic                  w_access;
  logic                  w_wr_en;
  logic [DATA_WIDTH-1:0] w_old;
  logic [DATA_WIDTH-1:0] w_merged;

  // State register; the reset state decides whether a clear pass runs on release.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) r_state <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_clear) w_next = S_CLEAR;
      S_CLEAR: if (r_clr_addr == LAST_ADDR) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state == S_CLEAR);
  end

  assign o_busy = w_busy;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_clr_addr <= '0;
    end else if (w_busy) begin
      if (r_clr_addr == LAST_ADDR) r_clr_addr <= '0;
      else                         r_clr_addr <= r_clr_addr + 1'b1;
    end
  end

  assign w_idx      = i_addr[IDX_W-1:0];
  assign w_in_range = ({1'b0, i_addr} < DEPTH_L);
  assign w_access   = i_cs && !w_busy;
  assign w_wr_en    = w_access && i_we && w_in_range;
  assign w_old      = w_in_range ? r_mem[w_idx] : '0;

  // Out-of-range words read as zero, including the write-first merge.
  always_comb begin
    w_merged = w_old;
    for (int k = 0; k < BE_WIDTH; k++) begin
      if (i_be[k]) w_merged[8*k +: 8] = i_din[8*k +: 8];
    end
    if (!w_in_range) w_merged = '0;
  end

  always_ff @(posedge clk) begin
    if (w_busy) begin
      r_mem[r_clr_addr] <= CLEAR_VALUE;
    end else if (w_wr_en) begin
      for (int k = 0; k < BE_WIDTH; k++) begin
        if (i_be[k]) r_mem[w_idx][8*k +: 8] <= i_din[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_dout   <= '0;
      r_dvalid <= 1'b0;
    end else begin
      r_dvalid <= 1'b0;
      if (w_access) begin
        if (!i_we) begin
          r_dout   <= w_old;
          r_dvalid <= 1'b1;
        end else if (RDW_MODE == 1) begin
          r_dout   <= w_merged;
          r_dvalid <= 1'b1;
        end else if (RDW_MODE == 2) begin
          r_dout   <= w_old;
          r_dvalid <= 1'b1;
        end
      end
    end
  end

  assign o_dout   = r_dout;
  assign o_dvalid = r_dvalid;

endmodule

// File: tb/tb_ram_sp_be_clr.sv
// Bench for ram_sp_be_clr: three instances (write-first, read-first with a short
// depth, no-output) checked every cycle against a word-array reference model.
module tb_ram_sp_be_clr;

  localparam int N = 3;
  localparam int              DEPTH [N] = '{256, 200, 256};
  localparam int              RDW   [N] = '{1, 2, 0};
  localparam int              COR   [N] = '{1, 0, 0};
  localparam logic [31:0]     CVAL  [N] = '{32'hA5A5A5A5, 32'h0F0F1234, 32'h00000000};

  logic        clk;
  logic        rst    [N];
  logic        cs     [N];
  logic        we     [N];
  logic [3:0]  be     [N];
  logic [7:0]  addr   [N];
  logic [31:0] din    [N];
  logic        clr    [N];
  logic [31:0] dout   [N];
  logic        dvalid [N];
  logic        busy   [N];

  int checks;
  int errors;

  // Reference model: word array, known-content flags, remaining clear cycles.
  logic [31:0] mem_m [N][256];
  bit          kn_m  [N][256];
  int          cnt_m [N];
  logic [31:0] edout [N];
  bit          edk   [N];
  bit          edv   [N];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ram_sp_be_clr #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .RAM_DEPTH(256), .RDW_MODE(1),
                  .CLEAR_ON_RESET(1), .CLEAR_VALUE(32'hA5A5A5A5)) u_dut_a (
    .clk(clk), .i_rst(rst[0]), .i_cs(cs[0]), .i_we(we[0]), .i_be(be[0]),
    .i_addr(addr[0]), .i_din(din[0]), .i_clear(clr[0]),
    .o_dout(dout[0]), .o_dvalid(dvalid[0]), .o_busy(busy[0]));

  ram_sp_be_clr #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .RAM_DEPTH(200), .RDW_MODE(2),
                  .CLEAR_ON_RESET(0), .CLEAR_VALUE(32'h0F0F1234)) u_dut_b (
    .clk(clk), .i_rst(rst[1]), .i_cs(cs[1]), .i_we(we[1]), .i_be(be[1]),
    .i_addr(addr[1]), .i_din(din[1]), .i_clear(clr[1]),
    .o_dout(dout[1]), .o_dvalid(dvalid[1]), .o_busy(busy[1]));

  ram_sp_be_clr #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .RAM_DEPTH(256), .RDW_MODE(0),
                  .CLEAR_ON_RESET(0), .CLEAR_VALUE(32'h00000000)) u_dut_c (
    .clk(clk), .i_rst(rst[2]), .i_cs(cs[2]), .i_we(we[2]), .i_be(be[2]),
    .i_addr(addr[2]), .i_din(din[2]), .i_clear(clr[2]),
    .o_dout(dout[2]), .o_dvalid(dvalid[2]), .o_busy(busy[2]));

  function automatic void mdl_reset(int d);
    cnt_m[d] = (COR[d] != 0) ? DEPTH[d] : 0;
    edout[d] = 32'h0;
    edk[d]   = 1'b1;
    edv[d]   = 1'b0;
  endfunction

  // One clock edge of the memory as seen by a client.
  function automatic void mdl_step(int d);
    logic [31:0] old_w;
    logic [31:0] new_w;
    bit          inr;
    bit          okv;
    int          pos;
    edv[d] = 1'b0;
    if (cnt_m[d] > 0) begin
      pos = DEPTH[d] - cnt_m[d];
      mem_m[d][pos] = CVAL[d];
      kn_m[d][pos]  = 1'b1;
      cnt_m[d]--;
      return;
    end
    if (cs[d]) begin
      inr   = int'(addr[d]) < DEPTH[d];
      old_w = inr ? mem_m[d][addr[d]] : 32'h0;
      okv   = !inr || kn_m[d][addr[d]];
      if (!we[d]) begin
        edv[d] = 1'b1; edout[d] = old_w; edk[d] = okv;
      end else begin
        new_w = old_w;
        for (int k = 0; k < 4; k++)
          if (be[d][k]) new_w[8*k +: 8] = din[d][8*k +: 8];
        if (inr) begin
          mem_m[d][addr[d]] = new_w;
          kn_m[d][addr[d]]  = okv || (be[d] == 4'hF);
        end
        if (RDW[d] == 1) begin
          edv[d] = 1'b1; edout[d] = inr ? new_w : 32'h0;
          edk[d] = !inr || okv || (be[d] == 4'hF);
        end else if (RDW[d] == 2) begin
          edv[d] = 1'b1; edout[d] = old_w; edk[d] = okv;
        end
      end
    end
    if (clr[d]) cnt_m[d] = DEPTH[d];
  endfunction

  // Advance one clock, update the model, compare all instances, return inputs to idle.
  task automatic tick();
    @(posedge clk);
    for (int d = 0; d < N; d++) if (!rst[d]) mdl_step(d);
    #1;
    for (int d = 0; d < N; d++) begin
      checks++;
      if (busy[d] !== (cnt_m[d] > 0)) begin
        errors++;
        $display("FAIL busy dut%0d t=%0t got %b want %b", d, $time, busy[d], cnt_m[d] > 0);
      end
      checks++;
      if (dvalid[d] !== edv[d]) begin
        errors++;
        $display("FAIL dvalid dut%0d t=%0t got %b want %b", d, $time, dvalid[d], edv[d]);
      end
      if (edk[d]) begin
        checks++;
        if (dout[d] !== edout[d]) begin
          errors++;
          $display("FAIL dout dut%0d t=%0t got %h want %h", d, $time, dout[d], edout[d]);
        end
      end
    end
    @(negedge clk);
    for (int d = 0; d < N; d++) begin
      cs[d] = 1'b0; we[d] = 1'b0; be[d] = 4'h0; addr[d] = 8'h0; din[d] = 32'h0; clr[d] = 1'b0;
    end
  endtask

  task automatic drive(int d, bit w, logic [3:0] b, logic [7:0] a, logic [31:0] v);
    cs[d] = 1'b1; we[d] = w; be[d] = b; addr[d] = a; din[d] = v;
  endtask

  task automatic wait_idle(int d);
    for (int i = 0; i < 1000 && busy[d]; i++) tick();
    checks++;
    if (busy[d] !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle dut%0d got busy %b want 0", d, busy[d]);
    end
  endtask

  // Pulses reset on one instance and measures the following clear pass length.
  task automatic do_reset(int d);
    int n;
    #2 rst[d] = 1'b1;
    mdl_reset(d);
    #1;
    checks++;
    if (dout[d] !== 32'h0 || dvalid[d] !== 1'b0 || busy[d] !== (COR[d] != 0)) begin
      errors++;
      $display("FAIL reset_async dut%0d got dout %h dvalid %b busy %b want 0 0 %b",
               d, dout[d], dvalid[d], busy[d], COR[d] != 0);
    end
    tick();
    tick();
    rst[d] = 1'b0;
    #1;
    n = busy[d] ? 1 : 0;
    for (int i = 0; i < 1000 && busy[d]; i++) begin
      tick();
      if (busy[d]) n++;
    end
    checks++;
    if (n != ((COR[d] != 0) ? DEPTH[d] : 0)) begin
      errors++;
      $display("FAIL reset_pass_len dut%0d got %0d want %0d", d, n, (COR[d] != 0) ? DEPTH[d] : 0);
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < N; d++) do_reset(d);
  endtask

  task automatic test_clear_pass();
    int n;
    for (int d = 1; d < N; d++) begin
      clr[d] = 1'b1;
      tick();
      n = 0;
      for (int i = 0; i < 1000 && busy[d]; i++) begin
        n++;
        tick();
      end
      checks++;
      if (n != DEPTH[d]) begin
        errors++;
        $display("FAIL clear_pass_len dut%0d got %0d want %0d", d, n, DEPTH[d]);
      end
    end
  endtask

  task automatic test_back_to_back();
    drive(0, 1'b0, 4'h0, 8'd0, 32'h0);   tick();
    drive(0, 1'b0, 4'h0, 8'd128, 32'h0); tick();
    drive(0, 1'b0, 4'h0, 8'd255, 32'h0); tick();
    tick();
    for (int d = 0; d < N; d++) begin
      for (int i = 0; i < 8; i++) begin
        drive(d, 1'b0, 4'h0, 8'($urandom_range(0, 255)), 32'h0);
        tick();
      end
    end
  endtask

  task automatic test_byte_enable();
    for (int d = 0; d < N; d++) begin
      drive(d, 1'b1, 4'hF, 8'd5, 32'h11223344);  tick();
      drive(d, 1'b1, 4'h5, 8'd5, 32'hAABBCCDD);  tick();
      drive(d, 1'b0, 4'h0, 8'd5, 32'h0);         tick();
      drive(d, 1'b1, 4'h0, 8'd5, 32'hDEADBEEF);  tick();
      drive(d, 1'b0, 4'h0, 8'd5, 32'h0);         tick();
    end
  endtask

  task automatic test_rdw();
    for (int d = 0; d < N; d++) begin
      drive(d, 1'b1, 4'hF, 8'd9, 32'h0);        tick();
      drive(d, 1'b1, 4'hF, 8'd9, 32'hCAFEF00D); tick();
      tick();
      drive(d, 1'b1, 4'h3, 8'd9, 32'h12345678); tick();
      drive(d, 1'b0, 4'h0, 8'd9, 32'h0);        tick();
    end
  endtask

  task automatic test_clear_interaction();
    for (int d = 0; d < N; d++) begin
      drive(d, 1'b1, 4'hF, 8'd3, 32'h5);
      clr[d] = 1'b1;
      tick();
      for (int i = 0; i < 6; i++) begin
        drive(d, 1'b1, 4'hF, 8'($urandom_range(0, 255)), $urandom);
        clr[d] = (i == 2);
        tick();
      end
      wait_idle(d);
      drive(d, 1'b0, 4'h0, 8'd3, 32'h0); tick();
    end
  endtask

  task automatic test_reset_mid_clear();
    clr[0] = 1'b1;
    tick();
    repeat (100) tick();
    do_reset(0);
    drive(0, 1'b0, 4'h0, 8'd100, 32'h0); tick();
  endtask

  task automatic test_out_of_range();
    drive(1, 1'b1, 4'hF, 8'd210, 32'h7);        tick();
    drive(1, 1'b0, 4'h0, 8'd210, 32'h0);        tick();
    drive(1, 1'b1, 4'hF, 8'd199, 32'h9ABCDEF0); tick();
    drive(1, 1'b0, 4'h0, 8'd199, 32'h0);        tick();
    drive(1, 1'b0, 4'h0, 8'd255, 32'h0);        tick();
    drive(1, 1'b0, 4'h0, 8'd82, 32'h0);         tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      for (int d = 0; d < N; d++) begin
        if ($urandom_range(0, 9) < 7)
          drive(d, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                8'($urandom_range(0, 255)), $urandom);
        clr[d] = ($urandom_range(0, 299) == 0);
      end
      tick();
    end
    for (int d = 0; d < N; d++) wait_idle(d);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    for (int d = 0; d < N; d++) begin
      rst[d] = 1'b1; cs[d] = 1'b0; we[d] = 1'b0; be[d] = 4'h0;
      addr[d] = 8'h0; din[d] = 32'h0; clr[d] = 1'b0;
      mdl_reset(d);
    end
    @(negedge clk);
    test_reset();
    test_clear_pass();
    test_back_to_back();
    test_byte_enable();
    test_rdw();
    test_clear_interaction();
    test_reset_mid_clear();
    test_out_of_range();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
